// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver (16x baud tick) feeding a first-word-fall-
//            through receive FIFO with sticky overrun / framing flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          baud_tick,
  input  logic          rxd,
  input  logic          rd_strobe,
  input  logic          err_clr,
  output logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic [AW:0]   fifo_count,
  output logic          overrun,
  output logic          frame_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic          r_rx_meta;
  logic          r_rxs;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_tc;
  logic [3:0]    w_tc_nxt;
  logic [2:0]    r_bi;
  logic [2:0]    w_bi_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_push_req;
  logic          w_frame_set;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rd_strobe_d;
  logic          r_overrun;
  logic          r_frame_err;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_overrun_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tc    <= 4'd0;
      r_bi    <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_tc    <= w_tc_nxt;
      r_bi    <= w_bi_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tc_nxt    = r_tc;
    w_bi_nxt    = r_bi;
    w_shift_nxt = r_shift;
    w_push_req  = 1'b0;
    w_frame_set = 1'b0;
    if (baud_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            w_state_nxt = S_START;
            w_tc_nxt    = 4'd0;
          end
        end
        S_START: begin
          // Mid start bit: a high level here means the falling edge was noise
          if (r_tc == 4'd7) begin
            w_tc_nxt = 4'd0;
            if (!r_rxs) begin
              w_state_nxt = S_DATA;
              w_bi_nxt    = 3'd0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tc_nxt = r_tc + 4'd1;
          end
        end
        S_DATA: begin
          w_tc_nxt = r_tc + 4'd1;
          if (r_tc == 4'd15) begin
            w_shift_nxt = {r_rxs, r_shift[7:1]};
            w_bi_nxt    = r_bi + 3'd1;
            if (r_bi == 3'd7) begin
              w_state_nxt = S_STOP;
            end
          end
        end
        S_STOP: begin
          w_tc_nxt = r_tc + 4'd1;
          if (r_tc == 4'd15) begin
            w_state_nxt = S_IDLE;
            w_push_req  = r_rxs;
            w_frame_set = ~r_rxs;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign w_full        = (r_count == c_full);
  assign w_pop         = rd_strobe & ~r_rd_strobe_d & (r_count != '0);
  assign w_push        = w_push_req & (~w_full | w_pop);
  assign w_overrun_set = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rd_strobe_d <= 1'b0;
    end else begin
      r_rd_strobe_d <= rd_strobe;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign rx_data    = (r_count == '0) ? 8'h00 : r_mem[r_rd_ptr];
  assign rx_ready   = (r_count != '0);
  assign fifo_count = r_count;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo (tick every 4 clk).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BIT_CLK = 64;

  logic          clk;
  logic          reset;
  logic          baud_tick;
  logic          rxd;
  logic          rd_strobe;
  logic          err_clr;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [AW:0]   fifo_count;
  logic          overrun;
  logic          frame_err;

  int total;
  int bad;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .rxd        (rxd),
    .rd_strobe  (rd_strobe),
    .err_clr    (err_clr),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  task automatic send_bits(input logic [7:0] d);
    rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  // A low stop is released early so the following idle is seen before the receiver re-arms
  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    send_bits(d);
    rxd = stop_val;
    repeat (stop_val ? BIT_CLK : 48) @(negedge clk);
    rxd = 1'b1;
    if (!stop_val) repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic pulse_read(output logic [7:0] got);
    @(negedge clk);
    rd_strobe = 1'b1;
    #1 got = rx_data;
    @(negedge clk);
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (rx_ready !== 1'b0 || fifo_count !== 5'd0 || rx_data !== 8'h00 ||
        overrun !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b count=%0d data=%h ovr=%b ferr=%b, want 0 0 00 0 0",
               rx_ready, fifo_count, rx_data, overrun, frame_err);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single;
    int waited;
    send_bits(8'hA5);
    rxd = 1'b1;
    total++;
    if (rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_early_ready: ready=%b want 0", rx_ready);
    end
    waited = 0;
    while (rx_ready !== 1'b1 && waited < BIT_CLK) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready_timeout: ready=%b want 1 within stop bit", rx_ready);
    end
    repeat (BIT_CLK - waited) @(negedge clk);
    total++;
    if (rx_data !== 8'hA5 || fifo_count !== 5'd1 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL single_byte: data=%h count=%0d ovr=%b ferr=%b, want a5 1 0 0",
               rx_data, fifo_count, overrun, frame_err);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got;
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    pulse_read(got);
    total++;
    if (got !== 8'hA5 || fifo_count !== 5'd0) begin
      bad++;
      $display("FAIL drain_a5: data=%h count=%0d, want a5 0", got, fifo_count);
    end
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    total++;
    if (fifo_count !== 5'd3) begin
      bad++;
      $display("FAIL b2b_count: count=%0d want 3", fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_read(got);
      total++;
      if (got !== exp[i] || fifo_count !== 5'(2 - i)) begin
        bad++;
        $display("FAIL b2b_read%0d: data=%h count=%0d, want %h %0d",
                 i, got, fifo_count, exp[i], 2 - i);
      end
    end
    total++;
    if (rx_data !== 8'h00 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_empty: data=%h ready=%b, want 00 0", rx_data, rx_ready);
    end
    pulse_read(got);
    total++;
    if (fifo_count !== 5'd0 || got !== 8'h00) begin
      bad++;
      $display("FAIL pop_empty: count=%0d data=%h, want 0 00", fifo_count, got);
    end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    total++;
    if (fifo_count !== 5'd0 || frame_err !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL glitch: count=%0d ferr=%b ready=%b, want 0 0 0",
               fifo_count, frame_err, rx_ready);
    end
  endtask

  task automatic test_frame_err;
    send_frame(8'h5A, 1'b0);
    total++;
    if (frame_err !== 1'b1 || fifo_count !== 5'd0) begin
      bad++;
      $display("FAIL frame_err_set: ferr=%b count=%0d, want 1 0", frame_err, fifo_count);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL frame_err_clr: ferr=%b want 0", frame_err);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] got;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1);
    total++;
    if (fifo_count !== 5'd16 || overrun !== 1'b0 || rx_data !== 8'h10) begin
      bad++;
      $display("FAIL fill: count=%0d ovr=%b data=%h, want 16 0 10", fifo_count, overrun, rx_data);
    end
    send_frame(8'hFF, 1'b1);
    total++;
    if (fifo_count !== 5'd16 || overrun !== 1'b1 || rx_data !== 8'h10) begin
      bad++;
      $display("FAIL overrun: count=%0d ovr=%b data=%h, want 16 1 10", fifo_count, overrun, rx_data);
    end
    pulse_read(got);
    total++;
    if (got !== 8'h10 || fifo_count !== 5'd15) begin
      bad++;
      $display("FAIL full_pop: data=%h count=%0d, want 10 15", got, fifo_count);
    end
    send_frame(8'h77, 1'b1);
    total++;
    if (fifo_count !== 5'd16) begin
      bad++;
      $display("FAIL refill: count=%0d want 16", fifo_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pulse_read(got);
      total++;
      if (got !== ((i == DEPTH - 1) ? 8'h77 : 8'h11 + 8'(i))) begin
        bad++;
        $display("FAIL drain%0d: data=%h want %h", i, got,
                 (i == DEPTH - 1) ? 8'h77 : 8'h11 + 8'(i));
      end
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (overrun !== 1'b0 || fifo_count !== 5'd0) begin
      bad++;
      $display("FAIL overrun_clr: ovr=%b count=%0d, want 0 0", overrun, fifo_count);
    end
  endtask

  task automatic test_reset_mid_frame;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    total++;
    if (fifo_count !== 5'd2) begin
      bad++;
      $display("FAIL pre_reset_count: count=%0d want 2", fifo_count);
    end
    rxd = 1'b0;
    repeat (200) @(negedge clk);
    reset = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (fifo_count !== 5'd0 || rx_ready !== 1'b0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset: count=%0d ready=%b data=%h, want 0 0 00",
               fifo_count, rx_ready, rx_data);
    end
    repeat (100) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    total++;
    if (rx_data !== 8'h3C || fifo_count !== 5'd1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_rx: data=%h count=%0d ferr=%b ovr=%b, want 3c 1 0 0",
               rx_data, fifo_count, frame_err, overrun);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    rxd       = 1'b1;
    rd_strobe = 1'b0;
    err_clr   = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
